// File: rtl/ika87ad_opfetch_pkg.sv
// Shared IKA87AD mnemonics: fetch FSM states, prefix bytes, page codes and
// the HARDI opcode that the fetcher injects for a hardware interrupt.
package IKA87AD_mnemonics;

  typedef enum logic [1:0] {
    FETCH1 = 2'd0,
    FETCH2 = 2'd1,
    HOLD   = 2'd2,
    WAIT   = 2'd3
  } fetch_st_e;

  localparam logic [7:0] PFX_48 = 8'h48;
  localparam logic [7:0] PFX_60 = 8'h60;
  localparam logic [7:0] PFX_64 = 8'h64;
  localparam logic [7:0] PFX_70 = 8'h70;
  localparam logic [7:0] PFX_74 = 8'h74;

  localparam logic [2:0] PAGE_NONE = 3'd0;
  localparam logic [2:0] PAGE_48   = 3'd1;
  localparam logic [2:0] PAGE_60   = 3'd2;
  localparam logic [2:0] PAGE_64   = 3'd3;
  localparam logic [2:0] PAGE_70   = 3'd4;
  localparam logic [2:0] PAGE_74   = 3'd5;

  localparam logic [7:0] OP_HARDI = 8'h73;

endpackage

// File: rtl/ika87ad_opfetch_pfxdet.sv
// Prefix detector: classifies an opcode byte as a page prefix and returns
// the page code it selects (PAGE_NONE for ordinary opcodes).
module ika87ad_pfxdet
  import IKA87AD_mnemonics::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_prefix,
  output logic [2:0] o_page
);

  // Byte -> {is_prefix, page} lookup
  always_comb begin
    o_is_prefix = 1'b1;
    o_page      = PAGE_NONE;
    case (i_byte)
      PFX_48:  o_page = PAGE_48;
      PFX_60:  o_page = PAGE_60;
      PFX_64:  o_page = PAGE_64;
      PFX_70:  o_page = PAGE_70;
      PFX_74:  o_page = PAGE_74;
      default: o_is_prefix = 1'b0;
    endcase
  end

endmodule

// File: rtl/ika87ad_opfetch.sv
// IKA87AD instruction fetch front end. Pulls opcode bytes from the bus unit,
// folds a prefix byte into a page code, holds one {opcode, page} for the
// microsequencer and owns the fetch address counter.
// Build option: IKA87AD_IRQ_INJECT_EN enables HARDI injection on i_IRQ_REQ.
module ika87ad_opfetch
  import IKA87AD_mnemonics::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        i_EMUCLK,
  input  logic        i_RESET_n,
  input  logic        i_CEN,
  input  logic [7:0]  i_FETCH_DATA,
  input  logic        i_FETCH_VALID,
  output logic        o_FETCH_READY,
  output logic [15:0] o_FETCH_ADDR,
  output logic [7:0]  o_OPCODE,
  output logic [2:0]  o_OPCODE_PAGE,
  output logic        o_OPCODE_VALID,
  output logic [15:0] o_OPCODE_PC,
  input  logic        i_OPCODE_ACCEPT,
  input  logic        i_ADDR_INC,
  input  logic        i_RESUME,
  input  logic        i_PC_LOAD,
  input  logic [15:0] i_PC_LOAD_VAL,
  input  logic        i_IRQ_REQ,
  output logic        o_IRQ_ACK
);

  fetch_st_e   state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  opc_q, opc_d;
  logic [2:0]  page_q, page_d;
  logic [2:0]  pfx_page_q, pfx_page_d;
  logic        valid_q, valid_d;
  logic        ack_q, ack_d;

  logic        is_pfx;
  logic [2:0]  det_page;
  logic        irq_take;
  logic        xfer;

  ika87ad_pfxdet u_pfxdet (
    .i_byte      (i_FETCH_DATA),
    .o_is_prefix (is_pfx),
    .o_page      (det_page)
  );

`ifdef IKA87AD_IRQ_INJECT_EN
  // Interrupt only lands on an instruction boundary, never after a prefix.
  assign irq_take = (state_q == FETCH1) && i_IRQ_REQ && !i_PC_LOAD;
`else
  logic unused_irq;
  assign unused_irq = i_IRQ_REQ;
  assign irq_take   = 1'b0;
`endif

  // Ready also drops while injecting so the bus unit never sees a byte
  // handshake complete that the fetcher did not actually consume.
  assign o_FETCH_READY = ((state_q == FETCH1) || (state_q == FETCH2)) &&
                         !i_PC_LOAD && !irq_take;
  assign xfer          = i_CEN && i_FETCH_VALID && o_FETCH_READY;

  assign o_FETCH_ADDR   = addr_q;
  assign o_OPCODE       = opc_q;
  assign o_OPCODE_PAGE  = page_q;
  assign o_OPCODE_VALID = valid_q;
  assign o_OPCODE_PC    = pc_q;
  assign o_IRQ_ACK      = ack_q;

  // Fetch FSM next state, address counter and held-opcode updates
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    opc_d      = opc_q;
    page_d     = page_q;
    pfx_page_d = pfx_page_q;
    valid_d    = valid_q;
    ack_d      = 1'b0;
    if (i_CEN) begin
      if (i_PC_LOAD) begin
        // Flush: drop held opcode and any half-fetched prefix.
        addr_d     = i_PC_LOAD_VAL;
        pc_d       = i_PC_LOAD_VAL;
        valid_d    = 1'b0;
        pfx_page_d = PAGE_NONE;
        state_d    = FETCH1;
      end else begin
        case (state_q)
          FETCH1: begin
            if (irq_take) begin
              // HARDI reports the un-advanced address as its return PC.
              opc_d   = OP_HARDI;
              page_d  = PAGE_NONE;
              valid_d = 1'b1;
              pc_d    = addr_q;
              ack_d   = 1'b1;
              state_d = HOLD;
            end else if (xfer) begin
              addr_d = addr_q + 16'd1;
              pc_d   = addr_q;
              if (is_pfx) begin
                pfx_page_d = det_page;
                state_d    = FETCH2;
              end else begin
                opc_d   = i_FETCH_DATA;
                page_d  = PAGE_NONE;
                valid_d = 1'b1;
                state_d = HOLD;
              end
            end else begin
              pc_d = addr_q;
            end
          end
          FETCH2: begin
            // Second byte is always the opcode, even if it looks like a prefix.
            if (xfer) begin
              addr_d     = addr_q + 16'd1;
              opc_d      = i_FETCH_DATA;
              page_d     = pfx_page_q;
              pfx_page_d = PAGE_NONE;
              valid_d    = 1'b1;
              state_d    = HOLD;
            end
          end
          HOLD: begin
            if (i_OPCODE_ACCEPT) begin
              valid_d = 1'b0;
              state_d = WAIT;
            end
          end
          WAIT: begin
            if (i_ADDR_INC) addr_d = addr_q + 16'd1;
            if (i_RESUME) begin
              pc_d    = addr_d;
              state_d = FETCH1;
            end
          end
          default: state_d = FETCH1;
        endcase
      end
    end
  end

  // State register; ack is a single-cycle pulse so it clears on every clock
  always_ff @(posedge i_EMUCLK or negedge i_RESET_n) begin
    if (!i_RESET_n) begin
      state_q    <= FETCH1;
      addr_q     <= RESET_PC;
      pc_q       <= 16'h0000;
      opc_q      <= 8'h00;
      page_q     <= PAGE_NONE;
      pfx_page_q <= PAGE_NONE;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      opc_q      <= opc_d;
      page_q     <= page_d;
      pfx_page_q <= pfx_page_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
    end
  end

endmodule
